ram16k_arbiter: RTL and testbench
=================================

RAM16K_ARBITER -- requirements
Module: ram16k_arbiter

Interface
REQ-001 Parameter AW, default 14, sets the RAM address width in bits.
REQ-002 Parameter DW, default 16, sets the RAM data width in bits.
REQ-003 CLK  input  1  the single clock; all state changes on its rising edge.
REQ-004 RST_N  input  1  asynchronous, active-low reset.
REQ-005 a_req / b_req  input  1  requester A / B asks for one RAM access.
REQ-006 a_we / b_we  input  1  the access is a write (1) or a read (0).
REQ-007 a_addr / b_addr  input  AW  word address of the access.
REQ-008 a_wdata / b_wdata  input  DW  write data (signed).
REQ-009 a_gnt / b_gnt  output  1  combinational grant; the access happens in this cycle.
REQ-010 a_rvalid / b_rvalid  output  1  registered; read data is valid for one cycle.
REQ-011 a_rdata / b_rdata  output  DW  registered read data (signed).
REQ-012 clr_start  input  1  one-cycle request to zero the whole RAM.
REQ-013 clr_busy  output  1  a clear sweep is in progress.
REQ-014 ram_in / ram_address / ram_load  output  DW / AW / 1  drive the RAM16K write port.
REQ-015 ram_out  input  DW  RAM16K combinational read data.

Function
REQ-016 The FSM SHALL have two states, RUN and CLEAR, and SHALL reset into RUN.
REQ-017 In RUN, one requester SHALL be granted per cycle: a sole requester wins; when both request, the requester not granted most recently wins.
REQ-018 The round-robin pointer SHALL update only on a cycle with a grant, and SHALL reset to favour A.
REQ-019 A granted write SHALL assert ram_load with the winner's addr/wdata in the grant cycle, so RAM is updated at that rising edge.
REQ-020 A granted read SHALL register ram_out into the winner's rdata at that edge, with rvalid high in the next cycle only (1-cycle latency).
REQ-021 rdata SHALL hold its last value when rvalid is low.
REQ-022 A requester SHALL hold req, we, addr and wdata stable until gnt; the arbiter does not queue requests.
REQ-023 A clr_start in RUN SHALL move the FSM to CLEAR at the next edge, even if a grant is issued in the same cycle (that access completes normally).
REQ-024 In CLEAR, a 14-bit counter SHALL sweep addresses 0 to 16383, writing 0 to one address per cycle with ram_load high.
REQ-025 The FSM SHALL return to RUN after address 16383 is written, so CLEAR lasts exactly 16384 cycles.
REQ-026 clr_busy SHALL equal (state == CLEAR).
REQ-027 In CLEAR, no gnt SHALL assert, and clr_start SHALL be ignored.
REQ-028 When no access is granted and the FSM is not in CLEAR, ram_load SHALL be 0.
REQ-029 Address wrap SHALL not occur; the counter SHALL be 0 whenever CLEAR is entered.

Reset
REQ-030 While RST_N is low, the block SHALL immediately force: state RUN, counter 0, pointer favouring A, rvalid 0, rdata 0, ram_load 0.
REQ-031 Reset during CLEAR SHALL abort the sweep without resuming it; RAM contents are left partially cleared.

Structure
REQ-032 Package ram16k_arb_pkg SHALL hold the state enum (RUN, CLEAR), AW, DW and CLR_LAST = 16383.
REQ-033 Sub-module rr_arb2 SHALL implement the two-way round-robin grant and pointer.
REQ-034 Implementation size: 120-400 lines of RTL.

Verification
REQ-035 After reset, A writes 0x1234 to address 5, then A reads address 5 -> a_gnt in each request cycle; a_rvalid one cycle after the read grant with a_rdata = 0x1234.
REQ-036 A and B both request continuously for 4 cycles, from reset -> grants go A, B, A, B.
REQ-037 Only B requests for 3 cycles -> b_gnt in all 3 cycles, and a_gnt stays 0.
REQ-038 Fill addresses 0, 8191 and 16383 with 0x7FFF, then pulse clr_start -> clr_busy high for exactly 16384 cycles, no grants during it, and all three addresses read back 0.
REQ-039 Assert RST_N low at clear cycle 100 -> clr_busy drops immediately; after release, address 99 reads 0 and address 200 reads its old value.
REQ-040 Pulse clr_start during CLEAR -> the sweep length is unchanged, and no second sweep follows.

Source files
------------

// File: rtl/ram16k_arb_pkg.sv
// Shared types and sizes for the RAM16K two-port arbiter.
package ram16k_arb_pkg;

    localparam int unsigned AW       = 14;
    localparam int unsigned DW       = 16;
    localparam int unsigned CLR_LAST = 16383;

    typedef enum logic {
        RUN   = 1'b0,
        CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, registered priority pointer.
module rr_arb2 (
    input  logic CLK,
    input  logic RST_N,
    input  logic en,
    input  logic a_req,
    input  logic b_req,
    output logic a_gnt_c,
    output logic b_gnt_c
);

    // 1 when B holds priority on a tie (A was the most recent winner)
    logic prio_b;

    // Grant the sole requester, or the one favoured by the pointer on a tie
    always_comb begin
        a_gnt_c = en && a_req && (!b_req || !prio_b);
        b_gnt_c = en && b_req && (!a_req ||  prio_b);
    end

    // Pointer moves only when something was granted
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            prio_b <= 1'b0;
        end else if (a_gnt_c) begin
            prio_b <= 1'b1;
        end else if (b_gnt_c) begin
            prio_b <= 1'b0;
        end
    end

endmodule

// File: rtl/ram16k_arbiter.sv
// Arbitrates two requesters onto one RAM16K port and provides a full-RAM clear sweep.
module ram16k_arbiter #(
    parameter int unsigned AW = ram16k_arb_pkg::AW,
    parameter int unsigned DW = ram16k_arb_pkg::DW
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 a_req,
    input  logic                 a_we,
    input  logic [AW-1:0]        a_addr,
    input  logic signed [DW-1:0] a_wdata,
    output logic                 a_gnt,
    output logic                 a_rvalid,
    output logic signed [DW-1:0] a_rdata,
    input  logic                 b_req,
    input  logic                 b_we,
    input  logic [AW-1:0]        b_addr,
    input  logic signed [DW-1:0] b_wdata,
    output logic                 b_gnt,
    output logic                 b_rvalid,
    output logic signed [DW-1:0] b_rdata,
    input  logic                 clr_start,
    output logic                 clr_busy,
    output logic signed [DW-1:0] ram_in,
    output logic [AW-1:0]        ram_address,
    output logic                 ram_load,
    input  logic signed [DW-1:0] ram_out
);

    import ram16k_arb_pkg::*;

    state_t        state;
    logic [AW-1:0] clr_cnt;
    logic          run_en;

    // Grants are only possible in RUN and never while reset is held
    assign run_en   = (state == RUN) && RST_N;
    assign clr_busy = (state == CLEAR);

    rr_arb2 u_rr_arb2 (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .en      (run_en),
        .a_req   (a_req),
        .b_req   (b_req),
        .a_gnt_c (a_gnt),
        .b_gnt_c (b_gnt)
    );

    // RAM port mux: clear sweep, else the granted requester, else idle
    always_comb begin
        ram_load    = 1'b0;
        ram_address = '0;
        ram_in      = '0;
        if (state == CLEAR) begin
            ram_load    = 1'b1;
            ram_address = clr_cnt;
        end else if (a_gnt) begin
            ram_load    = a_we;
            ram_address = a_addr;
            ram_in      = a_wdata;
        end else if (b_gnt) begin
            ram_load    = b_we;
            ram_address = b_addr;
            ram_in      = b_wdata;
        end
    end

    // RUN/CLEAR state and sweep counter; clr_start is ignored during a sweep
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= RUN;
            clr_cnt <= '0;
        end else if (state == RUN) begin
            if (clr_start) begin
                state   <= CLEAR;
                clr_cnt <= '0;
            end
        end else begin
            if (clr_cnt == AW'(CLR_LAST)) begin
                state   <= RUN;
                clr_cnt <= '0;
            end else begin
                clr_cnt <= clr_cnt + AW'(1);
            end
        end
    end

    // Capture read data for the granted reader; rdata holds between reads
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            a_rvalid <= 1'b0;
            a_rdata  <= '0;
            b_rvalid <= 1'b0;
            b_rdata  <= '0;
        end else begin
            a_rvalid <= a_gnt && !a_we;
            b_rvalid <= b_gnt && !b_we;
            if (a_gnt && !a_we) begin
                a_rdata <= ram_out;
            end
            if (b_gnt && !b_we) begin
                b_rdata <= ram_out;
            end
        end
    end

endmodule

// File: tb/tb_ram16k_arbiter.sv
// Randomised and directed bench for ram16k_arbiter with a RAM16K model and a reference model.
module tb_ram16k_arbiter;

    localparam int unsigned NWORDS = 16384;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        a_req = 1'b0, a_we = 1'b0;
    logic [13:0] a_addr = '0;
    logic [15:0] a_wdata = '0;
    logic        b_req = 1'b0, b_we = 1'b0;
    logic [13:0] b_addr = '0;
    logic [15:0] b_wdata = '0;
    logic        clr_start = 1'b0;
    logic        a_gnt, a_rvalid, b_gnt, b_rvalid, clr_busy, ram_load;
    logic [15:0] a_rdata, b_rdata, ram_in, ram_out;
    logic [13:0] ram_address;

    // RAM16K behaviour: combinational read, write at rising edge when loaded
    logic [15:0] ram [0:NWORDS-1];
    assign ram_out = ram[ram_address];
    always @(posedge CLK) begin
        if (ram_load) ram[ram_address] <= ram_in;
    end

    always #5 CLK = ~CLK;

    ram16k_arbiter dut (
        .CLK(CLK), .RST_N(RST_N),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .clr_start(clr_start), .clr_busy(clr_busy),
        .ram_in(ram_in), .ram_address(ram_address), .ram_load(ram_load),
        .ram_out(ram_out)
    );

    // Reference model: expected memory image and arbiter-visible state
    logic [15:0] ref_mem [0:NWORDS-1];
    bit          m_clear;
    int          m_cidx;
    int          m_last;        // most recent winner: 0 = A, 1 = B
    bit          m_rva, m_rvb, m_ga, m_gb;
    logic [15:0] m_rda, m_rdb;
    int          busy_cnt;
    int          checks = 0;
    int          failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: check grant-side outputs mid-cycle, advance model, check registered outputs
    task automatic step();
        bit          ga, gb, e_load;
        logic [13:0] e_addr;
        logic [15:0] e_in;
        @(negedge CLK);
        #1;
        ga = 0; gb = 0; e_load = 0; e_addr = '0; e_in = '0;
        if (m_clear) begin
            e_load = 1;
            e_addr = 14'(m_cidx);
        end else begin
            if (a_req && b_req) begin
                if (m_last == 1) ga = 1; else gb = 1;
            end else begin
                ga = a_req;
                gb = b_req;
            end
            if (ga && a_we) begin e_load = 1; e_addr = a_addr; e_in = a_wdata; end
            if (gb && b_we) begin e_load = 1; e_addr = b_addr; e_in = b_wdata; end
        end
        check("a_gnt", 32'(a_gnt), 32'(ga));
        check("b_gnt", 32'(b_gnt), 32'(gb));
        check("ram_load", 32'(ram_load), 32'(e_load));
        if (e_load) begin
            check("ram_address", 32'(ram_address), 32'(e_addr));
            check("ram_in", 32'(ram_in), 32'(e_in));
        end
        m_rva = ga && !a_we;
        m_rvb = gb && !b_we;
        if (m_rva) m_rda = ref_mem[a_addr];
        if (m_rvb) m_rdb = ref_mem[b_addr];
        if (ga && a_we) ref_mem[a_addr] = a_wdata;
        if (gb && b_we) ref_mem[b_addr] = b_wdata;
        if (ga) m_last = 0;
        if (gb) m_last = 1;
        if (m_clear) begin
            ref_mem[m_cidx] = '0;
            m_cidx++;
            if (m_cidx == int'(NWORDS)) m_clear = 0;
        end else if (clr_start) begin
            m_clear = 1;
            m_cidx  = 0;
        end
        m_ga = ga;
        m_gb = gb;
        @(posedge CLK);
        #1;
        check("a_rvalid", 32'(a_rvalid), 32'(m_rva));
        check("b_rvalid", 32'(b_rvalid), 32'(m_rvb));
        check("a_rdata", 32'(a_rdata), 32'(m_rda));
        check("b_rdata", 32'(b_rdata), 32'(m_rdb));
        check("clr_busy", 32'(clr_busy), 32'(m_clear));
        if (clr_busy) busy_cnt++;
    endtask

    task automatic do_reset();
        a_req = 0; b_req = 0; clr_start = 0;
        @(negedge CLK);
        RST_N = 0;
        #1;
        m_clear = 0; m_cidx = 0; m_last = 1;
        m_rva = 0; m_rvb = 0; m_rda = '0; m_rdb = '0; m_ga = 0; m_gb = 0;
        check("rst_clr_busy", 32'(clr_busy), 32'(m_clear));
        check("rst_a_rvalid", 32'(a_rvalid), 32'(m_rva));
        check("rst_b_rvalid", 32'(b_rvalid), 32'(m_rvb));
        check("rst_a_rdata", 32'(a_rdata), 32'(m_rda));
        check("rst_b_rdata", 32'(b_rdata), 32'(m_rdb));
        check("rst_ram_load", 32'(ram_load), 32'(0));
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST_N = 1;
        @(posedge CLK);
        #1;
    endtask

    task automatic acc_a(input logic we, input logic [13:0] addr, input logic [15:0] data);
        a_req = 1; a_we = we; a_addr = addr; a_wdata = data;
        step();
        a_req = 0;
    endtask

    task automatic acc_b(input logic we, input logic [13:0] addr, input logic [15:0] data);
        b_req = 1; b_we = we; b_addr = addr; b_wdata = data;
        step();
        b_req = 0;
    endtask

    // Watchdog so the run can never hang
    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < int'(NWORDS); i++) begin
            ram[i] = '0;
            ref_mem[i] = '0;
        end
        do_reset();

        // Both requesters from reset: alternate starting with A
        a_req = 1; a_we = 0; a_addr = 14'd1;
        b_req = 1; b_we = 0; b_addr = 14'd2;
        repeat (4) step();
        a_req = 0; b_req = 0;
        step();

        // Write then read back through A
        do_reset();
        acc_a(1'b1, 14'd5, 16'h1234);
        acc_a(1'b0, 14'd5, 16'h0000);
        step();

        // Only B for three cycles
        b_req = 1; b_we = 1; b_addr = 14'd7; b_wdata = 16'hBEEF;
        repeat (3) step();
        b_req = 0;
        acc_b(1'b0, 14'd7, 16'h0000);
        step();

        // Random traffic; each requester holds its request until granted
        for (int i = 0; i < 400; i++) begin
            if (!a_req || m_ga) begin
                a_req = ($urandom_range(0, 3) != 0);
                a_we = 1'($urandom);
                a_addr = 14'($urandom_range(0, 31));
                a_wdata = 16'($urandom);
            end
            if (!b_req || m_gb) begin
                b_req = ($urandom_range(0, 3) != 0);
                b_we = 1'($urandom);
                b_addr = 14'($urandom_range(0, 31));
                b_wdata = 16'($urandom);
            end
            step();
        end
        a_req = 0; b_req = 0;
        step();

        // Full clear sweep with a stray clr_start and held requests inside it
        acc_a(1'b1, 14'd0, 16'h7FFF);
        acc_b(1'b1, 14'd8191, 16'h7FFF);
        acc_a(1'b1, 14'd16383, 16'h7FFF);
        acc_b(1'b1, 14'd99, 16'h0099);
        acc_a(1'b1, 14'd200, 16'h0200);
        busy_cnt = 0;
        clr_start = 1;
        step();
        clr_start = 0;
        for (int i = 0; i < 17000 && m_clear; i++) begin
            clr_start = (i == 5000);
            if (i == 3000) begin
                a_req = 1; a_we = 0; a_addr = 14'd8191;
                b_req = 1; b_we = 1; b_addr = 14'd300; b_wdata = 16'h5555;
            end
            step();
        end
        clr_start = 0;
        check("clear_cycles", 32'(busy_cnt), 32'(NWORDS));
        repeat (2) step();
        a_req = 0; b_req = 0;
        repeat (20) step();
        check("no_second_sweep", 32'(busy_cnt), 32'(NWORDS));
        acc_a(1'b0, 14'd0, 16'h0000);
        acc_b(1'b0, 14'd8191, 16'h0000);
        acc_a(1'b0, 14'd16383, 16'h0000);
        acc_b(1'b0, 14'd300, 16'h0000);
        step();

        // Reset at clear cycle 100 aborts the sweep
        acc_a(1'b1, 14'd99, 16'h1199);
        acc_b(1'b1, 14'd200, 16'h2200);
        clr_start = 1;
        step();
        clr_start = 0;
        for (int i = 0; i < 200 && m_cidx < 100; i++) step();
        do_reset();
        repeat (3) step();
        acc_a(1'b0, 14'd99, 16'h0000);
        acc_b(1'b0, 14'd200, 16'h0000);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
